// File: rtl/lm07_spi_responder.sv
`timescale 1ns/1ps
// LM07 temperature sensor emulator: SPI slave that returns a 16-bit temperature
// frame MSB first, then accepts an optional shutdown configuration byte.
module lm07_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_WORD     = 16'h8100,
  parameter logic [10:0] TEMP_RESET  = 11'h000
) (
  input  logic        SYSCLK,
  input  logic        RSTN,
  input  logic        CS,
  input  logic        SCK,
  input  logic        SIO_IN,
  output logic        SIO_OUT,
  output logic        SIO_OE,
  input  logic [10:0] TEMP_IN,
  input  logic        TEMP_VALID,
  output logic        SHUTDOWN,
  output logic        FRAME_DONE
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] cs_sync_p0, sck_sync_p0, sio_sync_p0;
  logic                   cs_p1, sck_p1;
  logic                   cs_s, sck_s, sio_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [4:0]             cnt, cnt_nxt;
  logic signed [10:0]     temp_reg;
  logic [15:0]            shreg, shreg_nxt;
  logic [7:0]             wbyte, wbyte_nxt, wbyte_shift;
  logic                   sio_out_nxt, sio_oe_nxt, shutdown_nxt, frame_done_nxt;

  // Frame word as seen by the master for a given shutdown setting and temperature.
  function automatic logic [15:0] frame_word(input logic sd, input logic [10:0] t);
    return sd ? ID_WORD : {t, 5'b11111};
  endfunction

  // Stage p0: synchronizers; stage p1: previous synced value for edge detection
  assign cs_s  = cs_sync_p0[SYNC_STAGES-1];
  assign sck_s = sck_sync_p0[SYNC_STAGES-1];
  assign sio_s = sio_sync_p0[SYNC_STAGES-1];

  assign cs_fall  =  cs_p1  & ~cs_s;
  assign cs_rise  = ~cs_p1  &  cs_s;
  assign sck_rise = ~sck_p1 &  sck_s;
  assign sck_fall =  sck_p1 & ~sck_s;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    wbyte_nxt      = wbyte;
    sio_out_nxt    = SIO_OUT;
    sio_oe_nxt     = SIO_OE;
    shutdown_nxt   = SHUTDOWN;
    frame_done_nxt = 1'b0;
    wbyte_shift    = {wbyte[6:0], sio_s};

    // CS release aborts whatever is in flight, including a partial write byte
    if (cs_rise) begin
      state_nxt   = IDLE;
      sio_oe_nxt  = 1'b0;
      sio_out_nxt = 1'b0;
      cnt_nxt     = 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg_nxt   = frame_word(SHUTDOWN, TEMP_VALID ? TEMP_IN : temp_reg);
            sio_oe_nxt  = 1'b1;
            sio_out_nxt = shreg_nxt[15];
            cnt_nxt     = 5'd0;
            state_nxt   = READ;
          end
        end
        READ: begin
          if (sck_rise) begin
            cnt_nxt = cnt + 5'd1;
          end else if (sck_fall) begin
            if (cnt == 5'd16) begin
              sio_oe_nxt     = 1'b0;
              sio_out_nxt    = 1'b0;
              frame_done_nxt = 1'b1;
              cnt_nxt        = 5'd0;
              state_nxt      = WRITE;
            end else begin
              shreg_nxt   = {shreg[14:0], 1'b0};
              sio_out_nxt = shreg[14];
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            wbyte_nxt = wbyte_shift;
            cnt_nxt   = cnt + 5'd1;
            if (cnt == 5'd7) begin
              if (wbyte_shift == 8'hFF)      shutdown_nxt = 1'b1;
              else if (wbyte_shift == 8'h00) shutdown_nxt = 1'b0;
              cnt_nxt   = 5'd0;
              state_nxt = DONE;
            end
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control and observable state: asynchronous reset
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      cs_sync_p0  <= '1;
      sck_sync_p0 <= '0;
      sio_sync_p0 <= '0;
      cs_p1       <= 1'b1;
      sck_p1      <= 1'b0;
      state       <= IDLE;
      cnt         <= 5'd0;
      temp_reg    <= TEMP_RESET;
      SIO_OUT     <= 1'b0;
      SIO_OE      <= 1'b0;
      SHUTDOWN    <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      cs_sync_p0  <= {cs_sync_p0[SYNC_STAGES-2:0], CS};
      sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], SCK};
      sio_sync_p0 <= {sio_sync_p0[SYNC_STAGES-2:0], SIO_IN};
      cs_p1       <= cs_s;
      sck_p1      <= sck_s;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      if (TEMP_VALID) temp_reg <= TEMP_IN;
      SIO_OUT     <= sio_out_nxt;
      SIO_OE      <= sio_oe_nxt;
      SHUTDOWN    <= shutdown_nxt;
      FRAME_DONE  <= frame_done_nxt;
    end
  end

  // Shift registers are always loaded before use, so they carry no reset
  always_ff @(posedge SYSCLK) begin
    shreg <= shreg_nxt;
    wbyte <= wbyte_nxt;
  end

endmodule

// File: tb/tb_lm07_spi_responder.sv
`timescale 1ns/1ps
// Bench for lm07_spi_responder: an SPI master model drives frames and a
// scoreboard of expected read words is compared as each frame completes.
module tb_lm07_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;   // SYSCLK cycles per SCK half period

  logic        SYSCLK = 1'b0;
  logic        RSTN, CS, SCK, SIO_IN, TEMP_VALID;
  logic [10:0] TEMP_IN;
  logic        SIO_OUT, SIO_OE, SHUTDOWN, FRAME_DONE;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          fd_cnt = 0;
  logic [15:0] sb_q[$];
  logic [10:0] temp_m = 11'h000;
  logic        exp_sd = 1'b0;

  lm07_spi_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .ID_WORD    (16'h8100),
    .TEMP_RESET (11'h000)
  ) dut (
    .SYSCLK    (SYSCLK),
    .RSTN      (RSTN),
    .CS        (CS),
    .SCK       (SCK),
    .SIO_IN    (SIO_IN),
    .SIO_OUT   (SIO_OUT),
    .SIO_OE    (SIO_OE),
    .TEMP_IN   (TEMP_IN),
    .TEMP_VALID(TEMP_VALID),
    .SHUTDOWN  (SHUTDOWN),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 SYSCLK = ~SYSCLK;

  always @(negedge SYSCLK) if (FRAME_DONE === 1'b1) fd_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_frame();
    return exp_sd ? 16'h8100 : {temp_m, 5'b11111};
  endfunction

  task automatic load_temp(input logic [10:0] v);
    @(negedge SYSCLK);
    TEMP_IN = v; TEMP_VALID = 1'b1;
    @(negedge SYSCLK);
    TEMP_VALID = 1'b0;
    temp_m = v;
  endtask

  // One CS-framed transaction: nread read clocks, nwrite write clocks of wb.
  task automatic run_frame(input int nread, input int nwrite, input logic [7:0] wb,
                           input bit mid_upd, input logic [10:0] mid_val);
    logic [15:0] got;
    logic [15:0] exp_f;
    int          fd0;
    got = '0;
    fd0 = fd_cnt;
    if (nread == 16) sb_q.push_back(model_frame());
    @(negedge SYSCLK);
    CS = 1'b0;
    repeat (HALF) @(negedge SYSCLK);
    for (int i = 0; i < nread; i++) begin
      got = {got[14:0], SIO_OUT};
      if (i == 0)  chk("oe_first_bit", SIO_OE, 1'b1);
      if (i == 15) chk("oe_last_bit", SIO_OE, 1'b1);
      SCK = 1'b1;
      if (mid_upd && i == 5) begin
        TEMP_IN = mid_val; TEMP_VALID = 1'b1;
        @(negedge SYSCLK);
        TEMP_VALID = 1'b0;
        temp_m = mid_val;
        repeat (HALF-1) @(negedge SYSCLK);
      end else begin
        repeat (HALF) @(negedge SYSCLK);
      end
      SCK = 1'b0;
      repeat (HALF) @(negedge SYSCLK);
    end
    if (nread == 16) begin
      chk("oe_after_read", SIO_OE, 1'b0);
      chk("out_after_read", SIO_OUT, 1'b0);
    end
    for (int j = 0; j < nwrite; j++) begin
      SIO_IN = wb[7-j];
      repeat (HALF/2) @(negedge SYSCLK);
      SCK = 1'b1;
      repeat (HALF) @(negedge SYSCLK);
      SCK = 1'b0;
      repeat (HALF/2) @(negedge SYSCLK);
    end
    SIO_IN = 1'b0;
    if (nwrite == 8) begin
      if (wb == 8'hFF)      exp_sd = 1'b1;
      else if (wb == 8'h00) exp_sd = 1'b0;
    end
    CS = 1'b1;
    repeat (SYNC_STAGES+2) @(negedge SYSCLK);
    chk("oe_after_cs_rise", SIO_OE, 1'b0);
    chk("out_after_cs_rise", SIO_OUT, 1'b0);
    repeat (HALF) @(negedge SYSCLK);
    chk("frame_done_count", fd_cnt - fd0, (nread == 16) ? 1 : 0);
    chk("shutdown", SHUTDOWN, exp_sd);
    if (nread == 16) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        exp_f = sb_q.pop_front();
        chk("read_frame", got, exp_f);
      end
    end
  endtask

  initial begin
    RSTN = 1'b0; CS = 1'b1; SCK = 1'b0; SIO_IN = 1'b0;
    TEMP_IN = '0; TEMP_VALID = 1'b0;
    repeat (3) @(negedge SYSCLK);
    chk("rst_sio_out", SIO_OUT, 1'b0);
    chk("rst_sio_oe", SIO_OE, 1'b0);
    chk("rst_shutdown", SHUTDOWN, 1'b0);
    chk("rst_frame_done", FRAME_DONE, 1'b0);
    RSTN = 1'b1;
    repeat (4) @(negedge SYSCLK);

    // Basic temperature reads, including an update landing mid-frame
    load_temp(11'h0C8);
    run_frame(16, 0, 8'h00, 1'b0, 11'h000);
    load_temp(11'h7F0);
    run_frame(16, 0, 8'h00, 1'b1, 11'h000);
    run_frame(16, 0, 8'h00, 1'b0, 11'h000);

    // Shutdown configuration writes
    run_frame(16, 8, 8'hFF, 1'b0, 11'h000);
    run_frame(16, 8, 8'h5A, 1'b0, 11'h000);
    run_frame(16, 8, 8'h00, 1'b0, 11'h000);
    load_temp(11'h123);
    run_frame(16, 8, 8'h5A, 1'b0, 11'h000);
    run_frame(16, 5, 8'hFF, 1'b0, 11'h000);

    // Read aborted after 7 bits, then a clean frame
    run_frame(7, 0, 8'h00, 1'b0, 11'h000);
    run_frame(16, 0, 8'h00, 1'b0, 11'h000);

    // Reset in the middle of a read while in shutdown
    run_frame(16, 8, 8'hFF, 1'b0, 11'h000);
    @(negedge SYSCLK);
    CS = 1'b0;
    repeat (HALF) @(negedge SYSCLK);
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1;
      repeat (HALF) @(negedge SYSCLK);
      SCK = 1'b0;
      repeat (HALF) @(negedge SYSCLK);
    end
    chk("oe_before_midreset", SIO_OE, 1'b1);
    RSTN = 1'b0;
    #1;
    chk("midrst_sio_oe", SIO_OE, 1'b0);
    chk("midrst_sio_out", SIO_OUT, 1'b0);
    chk("midrst_shutdown", SHUTDOWN, 1'b0);
    chk("midrst_frame_done", FRAME_DONE, 1'b0);
    exp_sd = 1'b0;
    temp_m = 11'h000;
    @(negedge SYSCLK);
    CS = 1'b1;
    repeat (3) @(negedge SYSCLK);
    RSTN = 1'b1;
    repeat (4) @(negedge SYSCLK);
    for (int k = 0; k < 4; k++) begin
      SCK = 1'b1;
      repeat (6) @(negedge SYSCLK);
      chk("oe_sck_cs_high", SIO_OE, 1'b0);
      SCK = 1'b0;
      repeat (6) @(negedge SYSCLK);
      chk("oe_sck_cs_high", SIO_OE, 1'b0);
    end
    run_frame(16, 0, 8'h00, 1'b0, 11'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lm07_spi_responder.md
Name: lm07_spi_responder

Overview:
- SPI slave that emulates the LM07 temperature sensor for simulation and FPGA loopback testing of the LM07 reader.
- Answers a CS/SCK-clocked master with a 16-bit temperature frame, MSB first.
- Then accepts an optional 8-bit configuration byte that controls shutdown mode.
- Runs on SYSCLK; CS and SCK are treated as asynchronous inputs and oversampled.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for CS, SCK and SIO_IN; legal range 2..3.
- ID_WORD, 16'h8100: frame returned while in shutdown.
- TEMP_RESET, 11'h000: temperature register value after reset.

Ports:
- SYSCLK  in  1  system clock; must be at least 8x the SCK frequency.
- RSTN  in  1  reset, asynchronous, active-low.
- CS  in  1  chip select from master, active-low.
- SCK  in  1  serial clock from master; low when idle.
- SIO_IN  in  1  serial data from master, used during the write phase.
- SIO_OUT  out  1  serial data to master.
- SIO_OE  out  1  output enable for the SIO pad driver.
- TEMP_IN  in  11  two's-complement temperature, 0.25 C/LSB.
- TEMP_VALID  in  1  one-cycle strobe that loads TEMP_IN.
- SHUTDOWN  out  1  current shutdown configuration.
- FRAME_DONE  out  1  one-cycle pulse when a read frame completes (16 bits).

Behaviour:
- Reset (RSTN low, async):
  - Outputs: SIO_OUT=0, SIO_OE=0, SHUTDOWN=0, FRAME_DONE=0.
  - Internal: temperature register = TEMP_RESET; state = IDLE; bit counter = 0; synchronizer flops = CS 1, SCK 0, SIO_IN 0.
- Input conditioning:
  - CS, SCK and SIO_IN pass through SYNC_STAGES flops.
  - Edge detection uses the synced value against its previous value, giving these internal events:
    - cs_fall, cs_rise
    - sck_rise, sck_fall
- Temperature register:
  - Loads TEMP_IN on TEMP_VALID.
  - Frame contents come from a 16-bit snapshot taken on cs_fall.
  - A TEMP_VALID arriving during a frame updates the register but not the snapshot.
  - TEMP_VALID coinciding with cs_fall: the snapshot takes the new TEMP_IN.
- Frame format:
  - SHUTDOWN=0: {temp[10:0], 5'b11111}.
  - SHUTDOWN=1: ID_WORD.
- State machine:
  - IDLE: SIO_OE=0. On cs_fall: take snapshot, SIO_OE=1, SIO_OUT=snapshot[15], counter=0, go to READ.
  - READ:
    - Master samples on SCK rise.
    - On each sck_rise, counter increments.
    - On each sck_fall with counter<16, SIO_OUT shifts to the next lower bit.
    - On the sck_fall where counter==16: SIO_OE=0, SIO_OUT=0, FRAME_DONE pulses, counter=0, go to WRITE.
  - WRITE:
    - On each sck_rise, shift synced SIO_IN into an 8-bit register MSB first; counter increments.
    - When counter reaches 8, commit the byte:
      - 8'hFF sets SHUTDOWN=1.
      - 8'h00 clears SHUTDOWN=0.
      - Any other value leaves SHUTDOWN unchanged.
    - After the commit, go to DONE.
  - DONE: ignore SCK; wait for cs_rise.
- cs_rise in any state:
  - Go to IDLE immediately, with SIO_OE=0 and SIO_OUT=0 on the next cycle.
  - A partial write byte is discarded and SHUTDOWN is unchanged.
  - If cs_rise arrives before 16 read bits, FRAME_DONE does not pulse.
- Further SCK edges in DONE or IDLE have no effect.
- A SHUTDOWN change takes effect from the next frame.
- Latency: SIO_OUT updates SYNC_STAGES+1 SYSCLK cycles after the pin edge.
  - With SYSCLK >= 8x SCK, data settles well before the master's next sampling edge.
- Reset asserted mid-frame: all state returns to reset values at once, including SHUTDOWN=0.
- SCK toggling while CS is high: ignored, SIO_OE stays 0.

Test Plan:
- Load TEMP_IN=11'h0C8 (50.00 C); run a 16-clock frame with CS released after bit 16 -> master reads 16'h191F; SIO_OE high from CS fall to the 16th falling edge; FRAME_DONE pulses once.
- Load TEMP_IN=11'h7F0 (-4.00 C) -> read 16'hFE1F; then pulse TEMP_VALID with 11'h000 mid-frame -> the current frame still reads 16'hFE1F and the next frame reads 16'h001F.
- Full frame with write byte 8'hFF -> SHUTDOWN=1; next read returns 16'h8100; a further frame writing 8'h00 -> SHUTDOWN=0 and TEMP frames return.
- Write byte 8'h5A -> SHUTDOWN unchanged; write phase aborted after 5 bits of 8'hFF by CS rise -> SHUTDOWN stays 0.
- CS raised after 7 read bits -> SIO_OE=0 within SYNC_STAGES+2 cycles; no FRAME_DONE; the next frame starts cleanly at bit 15.
- RSTN pulsed low mid-READ, then a frame with SCK toggling while CS high -> outputs take reset values immediately; no SIO_OE activity until the next CS fall.
